// File: rtl/nv_nvdla_rt_mac2accu_pipe.sv
// Retiming pipe for the CMAC->CACC partial-sum bundle with in-flight count and idle flag.
// Optional build macro NVDLA_RT_MASK_DATA_GATE_EN: per-lane data load gated by the bundle mask.
module nv_nvdla_rt_mac2accu_pipe #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 22,
    parameter int unsigned PD_W   = 9,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic                     mac2accu_src_pvld,
    input  logic [LANES-1:0]         mac2accu_src_mask,
    input  logic                     mac2accu_src_mode,
    input  logic [LANES*DATA_W-1:0]  mac2accu_src_data,
    input  logic [PD_W-1:0]          mac2accu_src_pd,
    output logic                     mac2accu_dst_pvld,
    output logic [LANES-1:0]         mac2accu_dst_mask,
    output logic                     mac2accu_dst_mode,
    output logic [LANES*DATA_W-1:0]  mac2accu_dst_data,
    output logic [PD_W-1:0]          mac2accu_dst_pd,
    output logic [CNT_W-1:0]         rt_inflight_cnt,
    output logic                     rt_idle
);

    localparam int unsigned DW = LANES * DATA_W;
`ifdef NVDLA_RT_MASK_DATA_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    logic             pvld_q [STAGES];
    logic [LANES-1:0] mask_q [STAGES];
    logic             mode_q [STAGES];
    logic [PD_W-1:0]  pd_q   [STAGES];
    logic [DW-1:0]    data_q [STAGES];
    logic [CNT_W-1:0] cnt_q;

    logic             in_pvld [STAGES];
    logic [LANES-1:0] in_mask [STAGES];
    logic             in_mode [STAGES];
    logic [PD_W-1:0]  in_pd   [STAGES];
    logic [DW-1:0]    in_data [STAGES];

    // Stage inputs: stage 0 from the source, stage k from stage k-1.
    always_comb begin
        in_pvld[0] = mac2accu_src_pvld;
        in_mask[0] = mac2accu_src_mask;
        in_mode[0] = mac2accu_src_mode;
        in_pd[0]   = mac2accu_src_pd;
        in_data[0] = mac2accu_src_data;
        for (int k = 1; k < int'(STAGES); k++) begin
            in_pvld[k] = pvld_q[k-1];
            in_mask[k] = mask_q[k-1];
            in_mode[k] = mode_q[k-1];
            in_pd[k]   = pd_q[k-1];
            in_data[k] = data_q[k-1];
        end
    end

    // Valid is a pure shift; payload only loads behind a valid bundle.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                pvld_q[k] <= 1'b0;
                mask_q[k] <= '0;
                mode_q[k] <= 1'b0;
                pd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                pvld_q[k] <= in_pvld[k];
                if (in_pvld[k]) begin
                    mask_q[k] <= in_mask[k];
                    mode_q[k] <= in_mode[k];
                    pd_q[k]   <= in_pd[k];
                end
                for (int i = 0; i < int'(LANES); i++) begin
                    if (in_pvld[k] && (!GATE_EN || in_mask[k][i])) begin
                        data_q[k][i*DATA_W +: DATA_W] <= in_data[k][i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Tracks popcount of the valid chain: enter at src, leave at dst.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cnt_q <= '0;
        end else if (mac2accu_src_pvld && !pvld_q[STAGES-1]) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!mac2accu_src_pvld && pvld_q[STAGES-1]) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign mac2accu_dst_pvld = pvld_q[STAGES-1];
    assign mac2accu_dst_mask = mask_q[STAGES-1];
    assign mac2accu_dst_mode = mode_q[STAGES-1];
    assign mac2accu_dst_pd   = pd_q[STAGES-1];
    assign mac2accu_dst_data = data_q[STAGES-1];
    assign rt_inflight_cnt   = cnt_q;
    assign rt_idle           = !mac2accu_src_pvld && (cnt_q == '0);

endmodule

// File: tb/tb_nv_nvdla_rt_mac2accu_pipe.sv
// Bench for nv_nvdla_rt_mac2accu_pipe: four parameterisations share one stimulus stream,
// checked by a history-based model plus a directed table and hand-written sequences.
module tb_nv_nvdla_rt_mac2accu_pipe;

    localparam int ND = 4;
    localparam int HN = 4096;
    localparam int ST [ND] = '{2, 3, 1, 8};
    localparam int NL [ND] = '{8, 8, 16, 16};
    localparam int DWD [ND] = '{22, 22, 32, 32};
`ifdef NVDLA_RT_MASK_DATA_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        src_pvld;
    logic [15:0] src_mask;
    logic        src_mode;
    logic [8:0]  src_pd;
    logic [31:0] lane_in [16];
    logic [175:0] data_a;
    logic [511:0] data_c;

    always_comb begin
        data_a = '0;
        data_c = '0;
        for (int i = 0; i < 8; i++) data_a[i*22 +: 22] = lane_in[i][21:0];
        for (int i = 0; i < 16; i++) data_c[i*32 +: 32] = lane_in[i];
    end

    logic a_pvld, a_mode, a_idle, b_pvld, b_mode, b_idle, c_pvld, c_mode, c_idle, d_pvld, d_mode, d_idle;
    logic [7:0]   a_mask, b_mask;
    logic [15:0]  c_mask, d_mask;
    logic [8:0]   a_pd, b_pd, c_pd, d_pd;
    logic [175:0] a_data, b_data;
    logic [511:0] c_data, d_data;
    logic [3:0]   a_cnt, b_cnt, c_cnt, d_cnt;

    nv_nvdla_rt_mac2accu_pipe #(.STAGES(2), .LANES(8), .DATA_W(22), .PD_W(9), .CNT_W(4)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .mac2accu_src_pvld(src_pvld),
        .mac2accu_src_mask(src_mask[7:0]), .mac2accu_src_mode(src_mode), .mac2accu_src_data(data_a),
        .mac2accu_src_pd(src_pd), .mac2accu_dst_pvld(a_pvld), .mac2accu_dst_mask(a_mask),
        .mac2accu_dst_mode(a_mode), .mac2accu_dst_data(a_data), .mac2accu_dst_pd(a_pd),
        .rt_inflight_cnt(a_cnt), .rt_idle(a_idle));
    nv_nvdla_rt_mac2accu_pipe #(.STAGES(3), .LANES(8), .DATA_W(22), .PD_W(9), .CNT_W(4)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .mac2accu_src_pvld(src_pvld),
        .mac2accu_src_mask(src_mask[7:0]), .mac2accu_src_mode(src_mode), .mac2accu_src_data(data_a),
        .mac2accu_src_pd(src_pd), .mac2accu_dst_pvld(b_pvld), .mac2accu_dst_mask(b_mask),
        .mac2accu_dst_mode(b_mode), .mac2accu_dst_data(b_data), .mac2accu_dst_pd(b_pd),
        .rt_inflight_cnt(b_cnt), .rt_idle(b_idle));
    nv_nvdla_rt_mac2accu_pipe #(.STAGES(1), .LANES(16), .DATA_W(32), .PD_W(9), .CNT_W(4)) u_c (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .mac2accu_src_pvld(src_pvld),
        .mac2accu_src_mask(src_mask), .mac2accu_src_mode(src_mode), .mac2accu_src_data(data_c),
        .mac2accu_src_pd(src_pd), .mac2accu_dst_pvld(c_pvld), .mac2accu_dst_mask(c_mask),
        .mac2accu_dst_mode(c_mode), .mac2accu_dst_data(c_data), .mac2accu_dst_pd(c_pd),
        .rt_inflight_cnt(c_cnt), .rt_idle(c_idle));
    nv_nvdla_rt_mac2accu_pipe #(.STAGES(8), .LANES(16), .DATA_W(32), .PD_W(9), .CNT_W(4)) u_d (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .mac2accu_src_pvld(src_pvld),
        .mac2accu_src_mask(src_mask), .mac2accu_src_mode(src_mode), .mac2accu_src_data(data_c),
        .mac2accu_src_pd(src_pd), .mac2accu_dst_pvld(d_pvld), .mac2accu_dst_mask(d_mask),
        .mac2accu_dst_mode(d_mode), .mac2accu_dst_data(d_data), .mac2accu_dst_pd(d_pd),
        .rt_inflight_cnt(d_cnt), .rt_idle(d_idle));

    // Common view of all four instances.
    logic        o_pvld [ND];
    logic        o_mode [ND];
    logic        o_idle [ND];
    logic [15:0] o_mask [ND];
    logic [8:0]  o_pd   [ND];
    logic [3:0]  o_cnt  [ND];
    logic [31:0] o_lane [ND][16];

    always_comb begin
        o_pvld = '{a_pvld, b_pvld, c_pvld, d_pvld};
        o_mode = '{a_mode, b_mode, c_mode, d_mode};
        o_idle = '{a_idle, b_idle, c_idle, d_idle};
        o_mask = '{16'(a_mask), 16'(b_mask), c_mask, d_mask};
        o_pd   = '{a_pd, b_pd, c_pd, d_pd};
        o_cnt  = '{a_cnt, b_cnt, c_cnt, d_cnt};
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < 16; i++) o_lane[d][i] = '0;
        for (int i = 0; i < 8; i++) begin
            o_lane[0][i] = 32'(a_data[i*22 +: 22]);
            o_lane[1][i] = 32'(b_data[i*22 +: 22]);
        end
        for (int i = 0; i < 16; i++) begin
            o_lane[2][i] = c_data[i*32 +: 32];
            o_lane[3][i] = d_data[i*32 +: 32];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Input history, one entry per rising edge.
    logic        h_rst  [HN];
    logic        h_pvld [HN];
    logic        h_mode [HN];
    logic [15:0] h_mask [HN];
    logic [8:0]  h_pd   [HN];
    logic [31:0] h_lane [HN][16];
    int n_edge = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (n_edge < HN) begin
            h_rst[n_edge]  = rst;
            h_pvld[n_edge] = src_pvld;
            h_mode[n_edge] = src_mode;
            h_mask[n_edge] = src_mask;
            h_pd[n_edge]   = src_pd;
            for (int i = 0; i < 16; i++) h_lane[n_edge][i] = lane_in[i];
            n_edge = n_edge + 1;
        end
    end

    // Reference: dst shows the last surviving bundle that has had STAGES edges to travel.
    always @(negedge clk) begin : mdl
        int e, j, r, cnt, bad_lane;
        logic pv, md;
        logic [15:0] mk, lm;
        logic [8:0] pd;
        logic [31:0] ln, wm;
        if (chk_en && n_edge < HN) begin
            e = n_edge - 1;
            r = -1;
            for (int x = e; x >= 0; x--) if (h_rst[x]) begin r = x; break; end
            for (int d = 0; d < ND; d++) begin
                j = e - ST[d] + 1;
                pv = (j > r) && h_pvld[j];
                mk = '0; md = 1'b0; pd = '0;
                for (int x = j; x > r; x--)
                    if (h_pvld[x]) begin mk = h_mask[x]; md = h_mode[x]; pd = h_pd[x]; break; end
                cnt = 0;
                for (int x = e; x > r && x > e - ST[d]; x--) if (h_pvld[x]) cnt++;
                lm = (NL[d] == 16) ? 16'hFFFF : 16'h00FF;
                wm = (DWD[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << DWD[d]) - 32'h1);
                check($sformatf("mdl_ctl[%0d]", d), 64'({o_pvld[d], o_mask[d], o_mode[d], o_pd[d]}),
                      64'({pv, mk & lm, md, pd}));
                check($sformatf("mdl_cnt[%0d]", d), 64'(o_cnt[d]), 64'(cnt));
                check($sformatf("mdl_idle[%0d]", d), 64'(o_idle[d]), 64'(!src_pvld && cnt == 0));
                bad_lane = -1;
                ln = '0;
                for (int i = 0; i < NL[d]; i++) begin
                    ln = '0;
                    for (int x = j; x > r; x--)
                        if (h_pvld[x] && (!GATE || h_mask[x][i])) begin ln = h_lane[x][i]; break; end
                    ln = ln & wm;
                    if (o_lane[d][i] !== ln) begin bad_lane = i; break; end
                end
                if (bad_lane >= 0)
                    check($sformatf("mdl_data[%0d] lane%0d", d, bad_lane), 64'(o_lane[d][bad_lane]), 64'(ln));
                else
                    check($sformatf("mdl_data[%0d]", d), 64'(0), 64'(0 + (bad_lane + 1)));
            end
        end
    end

    typedef struct {
        logic pv; logic [7:0] mk; logic md; logic [8:0] pd; logic [21:0] l0, l4;
        logic epv; logic [7:0] emk; logic emd; logic [8:0] epd; logic [21:0] el0, el4;
        logic [3:0] ecnt; logic eidle;
    } row_t;

    task automatic drive(input logic pv, input logic [15:0] mk, input logic md, input logic [8:0] pd);
        src_pvld = pv; src_mask = mk; src_mode = md; src_pd = pd;
    endtask

    initial begin
        row_t tbl [8];
        logic [21:0] g5_l4, g6_l0;
        logic pat [7];
        logic exp_pat [7];
        g5_l4 = GATE ? 22'h0AAAA4 : 22'h0BBBB4;
        g6_l0 = GATE ? 22'h0BBBBB : 22'h0CCCCC;
        tbl[0] = '{1'b1, 8'hFF, 1'b1, 9'h1A5, 22'h00ABCD, 22'h000111,
                   1'b0, 8'h00, 1'b0, 9'h000, 22'h0, 22'h0, 4'd1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 9'h000, 22'h0, 22'h0,
                   1'b1, 8'hFF, 1'b1, 9'h1A5, 22'h00ABCD, 22'h000111, 4'd1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 9'h000, 22'h0, 22'h0,
                   1'b0, 8'hFF, 1'b1, 9'h1A5, 22'h00ABCD, 22'h000111, 4'd0, 1'b1};
        tbl[3] = '{1'b1, 8'hFF, 1'b0, 9'h0A0, 22'h0AAAAA, 22'h0AAAA4,
                   1'b0, 8'hFF, 1'b1, 9'h1A5, 22'h00ABCD, 22'h000111, 4'd1, 1'b0};
        tbl[4] = '{1'b1, 8'h0F, 1'b1, 9'h0B0, 22'h0BBBBB, 22'h0BBBB4,
                   1'b1, 8'hFF, 1'b0, 9'h0A0, 22'h0AAAAA, 22'h0AAAA4, 4'd2, 1'b0};
        tbl[5] = '{1'b1, 8'hF0, 1'b0, 9'h0C0, 22'h0CCCCC, 22'h0CCCC4,
                   1'b1, 8'h0F, 1'b1, 9'h0B0, 22'h0BBBBB, g5_l4, 4'd2, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 9'h000, 22'h0, 22'h0,
                   1'b1, 8'hF0, 1'b0, 9'h0C0, g6_l0, 22'h0CCCC4, 4'd1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 9'h000, 22'h0, 22'h0,
                   1'b0, 8'hF0, 1'b0, 9'h0C0, g6_l0, 22'h0CCCC4, 4'd0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 9'h0);
        for (int i = 0; i < 16; i++) lane_in[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ctl", 64'({a_pvld, a_mask, a_mode, a_pd, a_cnt, a_idle}), 64'({1'b0, 8'h0, 1'b0, 9'h0, 4'd0, 1'b1}));
        check("rst_data", 64'(a_data != '0), 64'(0));

        // Directed table on the STAGES=2 instance.
        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].pv, 16'(tbl[r].mk), tbl[r].md, tbl[r].pd);
            for (int i = 0; i < 16; i++) lane_in[i] = (i < 4) ? 32'(tbl[r].l0) : (i < 8) ? 32'(tbl[r].l4) : 32'h0;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_ctl", r), 64'({a_pvld, a_mask, a_mode, a_pd}),
                  64'({tbl[r].epv, tbl[r].emk, tbl[r].emd, tbl[r].epd}));
            check($sformatf("tbl%0d_data", r), 64'({a_data[0 +: 22], a_data[4*22 +: 22]}),
                  64'({tbl[r].el0, tbl[r].el4}));
            check($sformatf("tbl%0d_cnt", r), 64'(a_cnt), 64'(tbl[r].ecnt));
            check($sformatf("tbl%0d_idle", r), 64'(a_idle), 64'(tbl[r].eidle));
        end

        // Full-rate stream of 20 bundles through STAGES=2.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'($urandom), 1'($urandom), 9'(k));
            for (int i = 0; i < 16; i++) lane_in[i] = $urandom;
            @(posedge clk);
            #1;
            if (k >= 1) begin
                check($sformatf("stream_pd%0d", k - 1), 64'({a_pvld, a_pd}), 64'({1'b1, 9'(k - 1)}));
                check($sformatf("stream_cnt%0d", k), 64'(a_cnt), 64'(2));
            end
        end
        drive(1'b0, 16'h0, 1'b0, 9'h0);
        @(posedge clk);
        #1;
        check("stream_last", 64'({a_pvld, a_pd, a_cnt}), 64'({1'b1, 9'd19, 4'd1}));
        repeat (8) @(posedge clk);
        #1;

        // Reset with three bundles inside the STAGES=3 instance.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hFFFF, 1'b1, 9'(9'h40 + k));
            @(posedge clk);
            #1;
        end
        check("rstmid_full", 64'(b_cnt), 64'(3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 9'h0);
        check("rstmid_clear", 64'({b_pvld, b_cnt}), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rstmid_ghost%0d", k), 64'({b_pvld, b_cnt, b_idle}), 64'({1'b0, 4'd0, 1'b1}));
        end

        // Random traffic with occasional resets, checked by the model.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 9'($urandom));
            for (int i = 0; i < 16; i++) lane_in[i] = $urandom;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 9'h0);
        repeat (10) @(posedge clk);
        #1;

        // Bubble pattern 1,0,1,1,0 on STAGES=2.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            drive(pat[k], 16'($urandom), 1'($urandom), 9'(k));
            @(posedge clk);
            #1;
            check($sformatf("bubble%0d", k), 64'(a_pvld), 64'(exp_pat[k]));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
